// File: rtl/pop_scheduler_pkg.sv
// Shared types for the two-lane pop scheduler: FSM state encoding and lane identifiers.
package pop_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/pop_arbiter_core.sv
// Lane eligibility, strict lane-0 priority and lane-1 anti-starvation selection.
module pop_arbiter_core #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_i,
  input  logic [1:0] empty_i,
  input  logic [1:0] almost_empty_i,
  input  logic [1:0] almostfull_i,
  output logic [1:0] pop_o
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  logic [1:0]         pop_q;
  logic [1:0]         elig;
  logic               force_lane1;
  logic [StarveW-1:0] starve_q, starve_d;

  always_comb begin
    // A lane holding its last word cannot be popped again before its empty flag updates.
    elig        = ~empty_i & ~almostfull_i & ~(almost_empty_i & pop_q);
    force_lane1 = (starve_q == StarveMax) && elig[1];
    pop_o       = 2'b00;
    if (issue_i) begin
      if (force_lane1) begin
        pop_o[1] = 1'b1;
      end else if (elig[0]) begin
        pop_o[0] = 1'b1;
      end else if (elig[1]) begin
        pop_o[1] = 1'b1;
      end
    end
    starve_d = starve_q;
    if (pop_o[1]) begin
      starve_d = '0;
    end else if (pop_o[0] && elig[1] && (starve_q != StarveMax)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_q    <= 2'b00;
      starve_q <= '0;
    end else begin
      pop_q    <= pop_o;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/pop_scheduler.sv
// Two-lane FIFO pop scheduler: FSM, two-stage read pipeline and per-lane grant counters.
module pop_scheduler
  import pop_scheduler_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 fifo0_almost_empty,
  input  logic                 fifo1_almost_empty,
  input  logic                 fifo_up0_almostfull,
  input  logic                 fifo_up1_almostfull,
  input  logic [DATA_SIZE-1:0] in0,
  input  logic [DATA_SIZE-1:0] in1,
  output logic                 pop_0,
  output logic                 pop_1,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_lane,
  output logic                 busy,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1
);

  state_e               state_q, state_d;
  logic [1:0]           pop;
  logic                 issue;
  logic                 s1_valid_q, s1_lane_q;
  logic                 out_valid_q, out_lane_q;
  logic [DATA_SIZE-1:0] out_data_q;
  logic [15:0]          cnt0_q, cnt1_q;

  assign issue = (state_q == StActive) && enable;

  pop_arbiter_core #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arbiter (
    .clk            (clk),
    .reset          (reset),
    .issue_i        (issue),
    .empty_i        ({fifo_empty1, fifo_empty0}),
    .almost_empty_i ({fifo1_almost_empty, fifo0_almost_empty}),
    .almostfull_i   ({fifo_up1_almostfull, fifo_up0_almostfull}),
    .pop_o          (pop)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StActive;
      StActive: if (!enable) state_d = StDrain;
      StDrain: begin
        // The output stage completes on its own; only a word awaiting capture blocks IDLE.
        if (enable) begin
          state_d = StActive;
        end else if (!s1_valid_q) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      s1_valid_q  <= 1'b0;
      s1_lane_q   <= LANE0;
      out_valid_q <= 1'b0;
      out_lane_q  <= LANE0;
      out_data_q  <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= pop[0] | pop[1];
      s1_lane_q   <= pop[1] ? LANE1 : LANE0;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_lane_q <= s1_lane_q;
        out_data_q <= (s1_lane_q == LANE1) ? in1 : in0;
      end
      if (pop[0]) cnt0_q <= cnt0_q + 16'd1;
      if (pop[1]) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign pop_0      = pop[0];
  assign pop_1      = pop[1];
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_lane   = out_lane_q;
  assign busy       = (state_q == StActive) || (state_q == StDrain);
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_pop_scheduler.sv
// Directed self-checking bench for pop_scheduler.
`timescale 1ns/1ps
module tb_pop_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       fifo_empty0, fifo_empty1;
  logic       fifo0_almost_empty, fifo1_almost_empty;
  logic       fifo_up0_almostfull, fifo_up1_almostfull;
  logic [7:0] in0, in1;
  logic       pop_0, pop_1;
  logic [7:0] out_data;
  logic       out_valid, out_lane, busy;
  logic [15:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int errors = 0;

  pop_scheduler #(
    .DATA_SIZE  (8),
    .STARVE_MAX (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .fifo_empty0         (fifo_empty0),
    .fifo_empty1         (fifo_empty1),
    .fifo0_almost_empty  (fifo0_almost_empty),
    .fifo1_almost_empty  (fifo1_almost_empty),
    .fifo_up0_almostfull (fifo_up0_almostfull),
    .fifo_up1_almostfull (fifo_up1_almostfull),
    .in0                 (in0),
    .in1                 (in1),
    .pop_0               (pop_0),
    .pop_1               (pop_1),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_lane            (out_lane),
    .busy                (busy),
    .grant_cnt0          (grant_cnt0),
    .grant_cnt1          (grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle_inputs();
    enable = 0; fifo_empty0 = 1; fifo_empty1 = 1;
    fifo0_almost_empty = 0; fifo1_almost_empty = 0;
    fifo_up0_almostfull = 0; fifo_up1_almostfull = 0;
    in0 = 8'h00; in1 = 8'h00;
  endtask

  // Returns at a falling edge with reset just released; state is IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    set_idle_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    set_idle_inputs();
    enable = 1; fifo_empty0 = 0; fifo_empty1 = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pop_0 !== 1'b0) begin errors++; $display("FAIL rst_pop0 got %b exp 0", pop_0); end
    checks++; if (pop_1 !== 1'b0) begin errors++; $display("FAIL rst_pop1 got %b exp 0", pop_1); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_lane !== 1'b0) begin errors++; $display("FAIL rst_lane got %b exp 0", out_lane); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (grant_cnt0 !== 16'd0) begin errors++; $display("FAIL rst_cnt0 got %0d exp 0", grant_cnt0); end
    checks++; if (grant_cnt1 !== 16'd0) begin errors++; $display("FAIL rst_cnt1 got %0d exp 0", grant_cnt1); end
  endtask

  // Both lanes full: lane0 x4 then lane1 x1, repeating.
  task automatic test_starvation_rotation();
    logic exp_p0, exp_p1, exp_l;
    do_reset();
    in0 = 8'h3C; in1 = 8'hA5;
    fifo_empty0 = 0; fifo_empty1 = 0; enable = 1;
    #1;
    checks++; if ({pop_1, pop_0} !== 2'b00) begin errors++; $display("FAIL rot_idle got %b exp 00", {pop_1, pop_0}); end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); #1;
      exp_p1 = (((i - 1) % 5) == 4);
      exp_p0 = !exp_p1;
      checks++;
      if ({pop_1, pop_0} !== {exp_p1, exp_p0}) begin
        errors++; $display("FAIL rot_pop cyc %0d got %b exp %b", i, {pop_1, pop_0}, {exp_p1, exp_p0});
      end
      checks++;
      if (out_valid !== (i >= 3)) begin
        errors++; $display("FAIL rot_valid cyc %0d got %b exp %b", i, out_valid, (i >= 3));
      end
      if (i >= 3) begin
        exp_l = (((i - 3) % 5) == 4);
        checks++;
        if (out_lane !== exp_l || out_data !== (exp_l ? 8'hA5 : 8'h3C)) begin
          errors++; $display("FAIL rot_out cyc %0d got lane %b data %h exp lane %b", i, out_lane, out_data, exp_l);
        end
      end
    end
  endtask

  // Lane 0 holds a single word and its empty flag lags by one cycle.
  task automatic test_almost_empty();
    do_reset();
    in0 = 8'h77;
    fifo_empty0 = 0; fifo0_almost_empty = 1; enable = 1;
    @(negedge clk); #1;
    checks++; if (pop_0 !== 1'b1) begin errors++; $display("FAIL ae_pop got %b exp 1", pop_0); end
    @(negedge clk); #1;
    checks++; if ({pop_1, pop_0} !== 2'b00) begin errors++; $display("FAIL ae_nopop got %b exp 00", {pop_1, pop_0}); end
    @(negedge clk);
    fifo_empty0 = 1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77 || out_lane !== 1'b0) begin
      errors++; $display("FAIL ae_out got v %b d %h l %b exp v 1 d 77 l 0", out_valid, out_data, out_lane);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ae_single got %b exp 0", out_valid); end
    checks++; if (grant_cnt0 !== 16'd1) begin errors++; $display("FAIL ae_cnt0 got %0d exp 1", grant_cnt0); end
    checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL ae_hold got %h exp 77", out_data); end
  endtask

  // Expected granted lane for the backpressure scenario: -1 none.
  function automatic int bp_lane(int i);
    if (i >= 1 && i <= 6) return 1;
    if (i >= 7 && i <= 10) return 0;
    if (i == 11) return 1;
    return -1;
  endfunction

  task automatic test_backpressure();
    int el, eo;
    do_reset();
    in0 = 8'h11; in1 = 8'h99;
    fifo_empty0 = 0; fifo_empty1 = 0; fifo_up0_almostfull = 1; enable = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      fifo_up0_almostfull = (i < 7) || (i >= 12);
      fifo_up1_almostfull = (i >= 12);
      #1;
      el = bp_lane(i);
      checks++;
      if (pop_0 !== (el == 0) || pop_1 !== (el == 1)) begin
        errors++; $display("FAIL bp_pop cyc %0d got %b exp lane %0d", i, {pop_1, pop_0}, el);
      end
      eo = bp_lane(i - 2);
      checks++;
      if (out_valid !== (eo >= 0)) begin
        errors++; $display("FAIL bp_valid cyc %0d got %b exp %b", i, out_valid, (eo >= 0));
      end
      if (eo >= 0) begin
        checks++;
        if (out_lane !== eo[0] || out_data !== (eo == 1 ? 8'h99 : 8'h11)) begin
          errors++; $display("FAIL bp_out cyc %0d got lane %b data %h exp lane %0d", i, out_lane, out_data, eo);
        end
      end
    end
    checks++; if (grant_cnt1 !== 16'd7) begin errors++; $display("FAIL bp_cnt1 got %0d exp 7", grant_cnt1); end
  endtask

  task automatic test_drain();
    do_reset();
    in0 = 8'h42; fifo_empty0 = 0; enable = 1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dr_idle_busy got %b exp 0", busy); end
    @(negedge clk); #1;
    checks++; if (pop_0 !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL dr_pop1 got p %b b %b exp 1 1", pop_0, busy); end
    @(negedge clk); #1;
    checks++; if (pop_0 !== 1'b1) begin errors++; $display("FAIL dr_pop2 got %b exp 1", pop_0); end
    @(negedge clk);
    enable = 0;
    #1;
    checks++;
    if (pop_0 !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h42 || busy !== 1'b1) begin
      errors++; $display("FAIL dr_c3 got p %b v %b d %h b %b exp 0 1 42 1", pop_0, out_valid, out_data, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || pop_0 !== 1'b0) begin
      errors++; $display("FAIL dr_c4 got v %b b %b p %b exp 1 1 0", out_valid, busy, pop_0);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dr_c5 got v %b b %b exp 0 0", out_valid, busy);
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dr_c6_busy got %b exp 0", busy); end
    checks++; if (grant_cnt0 !== 16'd2) begin errors++; $display("FAIL dr_cnt0 got %0d exp 2", grant_cnt0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in0 = 8'h5E; fifo_empty0 = 0; enable = 1;
    @(negedge clk); #1;
    checks++; if (pop_0 !== 1'b1) begin errors++; $display("FAIL rm_pop got %b exp 1", pop_0); end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pop_0 !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_lane !== 1'b0) begin
      errors++; $display("FAIL rm_outs got v %b p %b b %b d %h l %b exp all 0", out_valid, pop_0, busy, out_data, out_lane);
    end
    checks++; if (grant_cnt0 !== 16'd0) begin errors++; $display("FAIL rm_cnt0 got %0d exp 0", grant_cnt0); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_hold got %b exp 0", out_valid); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (pop_0 !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_rel got p %b v %b exp 0 0", pop_0, out_valid); end
    @(negedge clk); #1;
    checks++; if (pop_0 !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_first got p %b v %b exp 1 0", pop_0, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_lat got %b exp 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5E) begin errors++; $display("FAIL rm_out got v %b d %h exp 1 5e", out_valid, out_data); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    in0 = 8'hE1; fifo_empty0 = 0; enable = 1;
    repeat (65536) @(negedge clk);
    #1;
    checks++; if (grant_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL wr_pre got %h exp ffff", grant_cnt0); end
    checks++; if (pop_0 !== 1'b1) begin errors++; $display("FAIL wr_pop got %b exp 1", pop_0); end
    @(negedge clk); #1;
    checks++; if (grant_cnt0 !== 16'h0000) begin errors++; $display("FAIL wr_wrap got %h exp 0000", grant_cnt0); end
    checks++; if (grant_cnt1 !== 16'h0000) begin errors++; $display("FAIL wr_cnt1 got %h exp 0000", grant_cnt1); end
  endtask

  initial begin
    test_reset();
    test_starvation_rotation();
    test_almost_empty();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pop_scheduler.md
POP_SCHEDULER -- requirements
Module: pop_scheduler

Interface
REQ-001 Parameter DATA_SIZE, default 8: lane data width in bits.
REQ-002 Parameter STARVE_MAX, default 4: number of consecutive lane-0 grants tolerated while lane 1 is eligible.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  scheduling permitted when high.
REQ-006 fifo_empty0, fifo_empty1  input  1 each  upstream FIFO empty flags.
REQ-007 fifo0_almost_empty, fifo1_almost_empty  input  1 each  upstream FIFO holds at most one word.
REQ-008 fifo_up0_almostfull, fifo_up1_almostfull  input  1 each  downstream lane backpressure.
REQ-009 in0, in1  input  DATA_SIZE each  upstream FIFO read data, valid the cycle after a pop.
REQ-010 pop_0, pop_1  output  1 each  combinational pop strobes to upstream FIFOs.
REQ-011 out_data  output  DATA_SIZE  registered granted word.
REQ-012 out_valid  output  1  out_data valid this cycle.
REQ-013 out_lane  output  1  source lane of out_data (0 or 1).
REQ-014 busy  output  1  high in ACTIVE or DRAIN state.
REQ-015 grant_cnt0, grant_cnt1  output  16 each  per-lane pop counters.

Function
REQ-016 FSM states IDLE, ACTIVE, DRAIN; IDLE->ACTIVE when enable=1; ACTIVE->DRAIN when enable=0; DRAIN->IDLE when no pop is in flight (pipeline stages empty); DRAIN->ACTIVE when enable returns to 1.
REQ-017 Pops are issued only in ACTIVE; pop_0 and pop_1 are never high in the same cycle.
REQ-018 Lane k eligible iff fifo_emptyk=0 AND fifo_upk_almostfull=0 AND NOT (fifok_almost_empty=1 AND pop_k was high the previous cycle).
REQ-019 Default strict priority: lane 0 granted when eligible, else lane 1 when eligible, else no pop.
REQ-020 Starvation counter (width ceil(log2(STARVE_MAX+1))): increments on a lane-0 grant while lane 1 is eligible; clears on any lane-1 grant; saturates at STARVE_MAX.
REQ-021 When the counter equals STARVE_MAX and lane 1 is eligible, lane 1 is granted regardless of lane 0.
REQ-022 Pop at cycle t: in<lane> sampled at cycle t+1; out_data/out_lane/out_valid presented in cycle t+2 (two-cycle latency), one out_valid pulse per pop.
REQ-023 Back-to-back pops allowed on either lane; sustained throughput one word per cycle.
REQ-024 out_valid is low in every cycle with no matching pop two cycles earlier; out_data holds its last value when out_valid is low.
REQ-025 grant_cntk increments on every pop_k; wraps 16'hFFFF->0.
REQ-026 Backpressure asserted mid-burst blocks new pops that same cycle; words already popped still complete per REQ-022.

Reset
REQ-027 During reset: state=IDLE, pop_0=pop_1=0, out_valid=0, out_lane=0, out_data=0, busy=0, grant counters=0, starvation counter=0, pipeline stages cleared.
REQ-028 Reset asserted mid-operation discards in-flight words with no out_valid; first pop possible in the first ACTIVE cycle after reset release.

Structure
REQ-029 FSM state encoding and the lane identifiers (LANE0=0, LANE1=1) belong in the shared package; DATA_SIZE and STARVE_MAX remain module parameters.
REQ-030 Eligibility/priority/starvation selection is a sub-module, pop_arbiter_core; the pipeline, FSM and counters stay in pop_scheduler.

Verification
REQ-031 Both lanes full, no backpressure, enable=1 -> pops lane0 x4, lane1 x1, repeating; out_lane sequence 0,0,0,0,1 starting 2 cycles after first pop.
REQ-032 Lane 0 holds one word (almost_empty=1, empty flag lagging 1 cycle) -> exactly one pop_0, no second pop next cycle; single out_valid.
REQ-033 fifo_up0_almostfull=1 with both lanes non-empty -> only pop_1 issued; out_lane=1 on all outputs; starvation counter stays 0.
REQ-034 enable dropped with 2 pops in flight -> DRAIN; two out_valid pulses; IDLE one cycle after last; busy low thereafter.
REQ-035 Reset asserted one cycle after a pop -> no out_valid for that word; all outputs at reset values; grant counters 0.
REQ-036 Preload grant_cnt0 near wrap (65535 pops) -> next pop_0 yields grant_cnt0=0.
